bit_stuff_serializer: RTL and testbench



---
 rtl/usb_sie_pkg.sv | 15 +
 rtl/bit_stuff_serializer_if.sv | 28 ++
 rtl/bit_stuff_serializer.sv | 123 ++++++++++++
 tb/tb_bit_stuff_serializer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/usb_sie_pkg.sv
// Shared constants and state encoding for the Serial Interface Engine bit-level stages.
// Both the transmit stuffer and the receive destuffer take their run length from here.
package usb_sie_pkg;

    localparam int USB_STUFF_LEN = 6;
    localparam int USB_BYTE_W    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        STUFF = 2'd2,
        EOP   = 2'd3
    } stuff_state_t;

endpackage

// File: rtl/bit_stuff_serializer_if.sv
// Byte handshake into the serializer plus its pre-NRZI line outputs.
// master = byte source / line consumer, slave = the serializer.
interface bit_stuff_serializer_if
    import usb_sie_pkg::*;
#(
    parameter int DATA_W = USB_BYTE_W
);

    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_last;
    logic              tx_ready;
    logic              data_out;
    logic              bit_valid;
    logic              eop;
    logic              underrun;

    modport master (
        output tx_valid, tx_data, tx_last,
        input  tx_ready, data_out, bit_valid, eop, underrun
    );

    modport slave (
        input  tx_valid, tx_data, tx_last,
        output tx_ready, data_out, bit_valid, eop, underrun
    );

endinterface

// File: rtl/bit_stuff_serializer.sv
// LSB-first byte serializer with USB zero-stuffing; byte accepted at edge N shows bit 0 in cycle N+1.
// tx_ready only in IDLE or on the last line bit of a non-final byte, so bytes chain with no bubble.
module bit_stuff_serializer
    import usb_sie_pkg::*;
#(
    parameter int DATA_W    = USB_BYTE_W,
    parameter int STUFF_LEN = USB_STUFF_LEN
) (
    input  logic                   clk,
    input  logic                   rst,
    bit_stuff_serializer_if.slave  bus
);

    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int OW = $clog2(STUFF_LEN + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(DATA_W - 1);
    localparam logic [OW-1:0] RUN_M1   = OW'(STUFF_LEN - 1);

    stuff_state_t      state, state_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic [CW-1:0]     bit_cnt, bit_cnt_n;
    logic [OW-1:0]     ones_cnt, ones_cnt_n;
    logic              last_q, last_n;
    logic              underrun_n;

    logic              data_q, valid_q, eop_q, underrun_q;
    logic              cur_bit, last_bit, stuff_next, boundary, ready;

    // boundary marks the cycle carrying the byte's final line bit (data or stuffed zero)
    always_comb begin
        cur_bit    = shreg[0];
        last_bit   = (bit_cnt == LAST_IDX);
        stuff_next = (state == SHIFT) && cur_bit && (ones_cnt == RUN_M1);
        boundary   = ((state == SHIFT) && last_bit && !stuff_next) ||
                     ((state == STUFF) && (bit_cnt == '0));
        ready      = rst && ((state == IDLE) || (boundary && !last_q));
    end

    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        bit_cnt_n  = bit_cnt;
        ones_cnt_n = ones_cnt;
        last_n     = last_q;
        underrun_n = 1'b0;

        case (state)
            IDLE: begin
                if (ready && bus.tx_valid) begin
                    shreg_n    = bus.tx_data;
                    bit_cnt_n  = '0;
                    ones_cnt_n = '0;
                    last_n     = bus.tx_last;
                    state_n    = SHIFT;
                end
            end
            SHIFT: begin
                shreg_n    = shreg >> 1;
                bit_cnt_n  = last_bit ? '0 : bit_cnt + 1'b1;
                ones_cnt_n = cur_bit ? ones_cnt + 1'b1 : '0;
                if (stuff_next) begin
                    state_n = STUFF;
                end
            end
            STUFF: begin
                ones_cnt_n = '0;
                state_n    = SHIFT;
            end
            EOP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // The ones run deliberately survives a chained byte load.
        if (boundary) begin
            if (last_q) begin
                state_n = EOP;
            end else if (bus.tx_valid) begin
                shreg_n   = bus.tx_data;
                bit_cnt_n = '0;
                last_n    = bus.tx_last;
                state_n   = SHIFT;
            end else begin
                underrun_n = 1'b1;
                state_n    = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            ones_cnt   <= '0;
            last_q     <= 1'b0;
            data_q     <= 1'b1;
            valid_q    <= 1'b0;
            eop_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            bit_cnt    <= bit_cnt_n;
            ones_cnt   <= ones_cnt_n;
            last_q     <= last_n;
            data_q     <= (state_n == SHIFT) ? shreg_n[0] : (state_n != STUFF);
            valid_q    <= (state_n == SHIFT) || (state_n == STUFF);
            eop_q      <= (state_n == EOP);
            underrun_q <= underrun_n;
        end
    end

    assign bus.tx_ready  = ready;
    assign bus.data_out  = data_q;
    assign bus.bit_valid = valid_q;
    assign bus.eop       = eop_q;
    assign bus.underrun  = underrun_q;

endmodule

// File: tb/tb_bit_stuff_serializer.sv
// Directed bench for bit_stuff_serializer: hand-computed line-bit strings and eop/underrun timing.
module tb_bit_stuff_serializer;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    bit_stuff_serializer_if #(.DATA_W(8)) bus ();

    bit_stuff_serializer #(.DATA_W(8), .STUFF_LEN(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] pk_data [4];
    int         pk_n;
    int         pk_supply;
    string      obs;
    int         first_cyc, last_cyc, eop_at, und_at, eop_cnt, und_cnt, overlap;
    int         acc_at [4];
    logic       rdy_at_und;
    bit         timeout;

    // Cycle 0 is the negedge before the first accept edge; outputs are sampled every negedge.
    task automatic run_packet();
        int  idx;
        int  cyc;
        int  tail;
        bit  hs;
        obs = ""; first_cyc = -1; last_cyc = -1; eop_at = -1; und_at = -1;
        eop_cnt = 0; und_cnt = 0; overlap = 0; rdy_at_und = 1'bx;
        for (int i = 0; i < 4; i++) acc_at[i] = -1;
        idx = 0; cyc = 0; tail = -1; hs = 0; timeout = 1;
        while (cyc < 200) begin
            @(negedge clk);
            if (bus.bit_valid) begin
                obs = {obs, bus.data_out ? "1" : "0"};
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            if (bus.eop) begin eop_cnt++; eop_at = cyc; end
            if (bus.underrun) begin und_cnt++; und_at = cyc; rdy_at_und = bus.tx_ready; end
            if ((bus.eop || bus.underrun) && bus.bit_valid) overlap++;
            if (hs) idx++;
            if (idx < pk_supply) begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = pk_data[idx];
                bus.tx_last  = (idx == pk_n - 1);
            end else begin
                bus.tx_valid = 1'b0;
                bus.tx_data  = 8'h00;
                bus.tx_last  = 1'b0;
            end
            hs = bus.tx_valid && bus.tx_ready;
            if (hs) acc_at[idx] = cyc;
            if (tail < 0 && (eop_cnt + und_cnt) > 0) tail = cyc + 2;
            if (cyc == tail) begin
                timeout = 0;
                break;
            end
            cyc++;
        end
    endtask

    function automatic string model_bits(input int n);
        string s;
        int    ones;
        logic  b;
        s = ""; ones = 0;
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 8; i++) begin
                b = pk_data[k][i];
                s = {s, b ? "1" : "0"};
                ones = b ? ones + 1 : 0;
                if (ones == 6) begin
                    s = {s, "0"};
                    ones = 0;
                end
            end
        end
        return s;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (bus.tx_ready !== 1'b0) begin bad++; $display("FAIL rst_tx_ready got=%b want=0", bus.tx_ready); end
        total++; if (bus.data_out !== 1'b1) begin bad++; $display("FAIL rst_data_out got=%b want=1", bus.data_out); end
        total++; if (bus.bit_valid !== 1'b0) begin bad++; $display("FAIL rst_bit_valid got=%b want=0", bus.bit_valid); end
        total++; if ({bus.eop, bus.underrun} !== 2'b00) begin bad++; $display("FAIL rst_eop_underrun got=%b want=00", {bus.eop, bus.underrun}); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (bus.tx_ready !== 1'b1) begin bad++; $display("FAIL idle_tx_ready got=%b want=1", bus.tx_ready); end
        total++; if (bus.bit_valid !== 1'b0) begin bad++; $display("FAIL idle_bit_valid got=%b want=0", bus.bit_valid); end
    endtask

    task automatic test_single_byte();
        pk_data[0] = 8'h80; pk_n = 1; pk_supply = 1;
        run_packet();
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL single_timeout got=%b want=0", timeout); end
        total++; if (obs != "00000001") begin bad++; $display("FAIL single_bits got=%s want=00000001", obs); end
        total++; if (first_cyc !== 1) begin bad++; $display("FAIL single_latency got=%0d want=1", first_cyc); end
        total++; if (eop_at !== 9 || eop_cnt !== 1) begin bad++; $display("FAIL single_eop at=%0d cnt=%0d want at=9 cnt=1", eop_at, eop_cnt); end
        total++; if (und_cnt !== 0 || overlap !== 0) begin bad++; $display("FAIL single_flags und=%0d ovl=%0d want 0 0", und_cnt, overlap); end
    endtask

    task automatic test_back_to_back();
        pk_data[0] = 8'hFF; pk_data[1] = 8'hFF; pk_n = 2; pk_supply = 2;
        run_packet();
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL b2b_timeout got=%b want=0", timeout); end
        total++; if (obs != "111111011111101111") begin bad++; $display("FAIL b2b_bits got=%s want=111111011111101111", obs); end
        total++; if (acc_at[1] !== 9) begin bad++; $display("FAIL b2b_accept got=%0d want=9", acc_at[1]); end
        total++; if (last_cyc - first_cyc + 1 !== 18) begin bad++; $display("FAIL b2b_contiguous span=%0d want=18", last_cyc - first_cyc + 1); end
        total++; if (eop_at !== 19 || eop_cnt !== 1) begin bad++; $display("FAIL b2b_eop at=%0d cnt=%0d want at=19 cnt=1", eop_at, eop_cnt); end
    endtask

    task automatic test_stuff_at_end();
        pk_data[0] = 8'hFC; pk_n = 1; pk_supply = 1;
        run_packet();
        total++; if (obs != "001111110") begin bad++; $display("FAIL end_stuff_bits got=%s want=001111110", obs); end
        total++; if (eop_at !== 10 || overlap !== 0) begin bad++; $display("FAIL end_stuff_eop at=%0d ovl=%0d want at=10 ovl=0", eop_at, overlap); end
    endtask

    task automatic test_stuff_across();
        pk_data[0] = 8'hF0; pk_data[1] = 8'h03; pk_n = 2; pk_supply = 2;
        run_packet();
        total++; if (obs != "00001111110000000") begin bad++; $display("FAIL across_bits got=%s want=00001111110000000", obs); end
        total++; if (acc_at[1] !== 8) begin bad++; $display("FAIL across_accept got=%0d want=8", acc_at[1]); end
        total++; if (eop_at !== 18 || und_cnt !== 0) begin bad++; $display("FAIL across_eop at=%0d und=%0d want at=18 und=0", eop_at, und_cnt); end
    endtask

    task automatic test_underrun();
        pk_data[0] = 8'h5A; pk_n = 2; pk_supply = 1;
        run_packet();
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL und_timeout got=%b want=0", timeout); end
        total++; if (obs != "01011010") begin bad++; $display("FAIL und_bits got=%s want=01011010", obs); end
        total++; if (und_at !== 9 || und_cnt !== 1) begin bad++; $display("FAIL und_pulse at=%0d cnt=%0d want at=9 cnt=1", und_at, und_cnt); end
        total++; if (eop_cnt !== 0 || overlap !== 0) begin bad++; $display("FAIL und_no_eop eop=%0d ovl=%0d want 0 0", eop_cnt, overlap); end
        total++; if (rdy_at_und !== 1'b1) begin bad++; $display("FAIL und_ready got=%b want=1", rdy_at_und); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.tx_valid = 1'b1; bus.tx_data = 8'hAA; bus.tx_last = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        total++; if ({bus.bit_valid, bus.data_out} !== 2'b11) begin bad++; $display("FAIL mid_bit3 got=%b want=11", {bus.bit_valid, bus.data_out}); end
        rst = 1'b0;
        #1;
        total++; if ({bus.bit_valid, bus.data_out, bus.tx_ready} !== 3'b010) begin bad++; $display("FAIL mid_rst_outputs got=%b want=010", {bus.bit_valid, bus.data_out, bus.tx_ready}); end
        @(negedge clk);
        total++; if ({bus.eop, bus.underrun} !== 2'b00) begin bad++; $display("FAIL mid_rst_flags got=%b want=00", {bus.eop, bus.underrun}); end
        rst = 1'b1;
        @(negedge clk);
        pk_data[0] = 8'h01; pk_n = 1; pk_supply = 1;
        run_packet();
        total++; if (obs != "10000000") begin bad++; $display("FAIL mid_after_bits got=%s want=10000000", obs); end
        total++; if (eop_at !== 9 || und_cnt !== 0) begin bad++; $display("FAIL mid_after_eop at=%0d und=%0d want at=9 und=0", eop_at, und_cnt); end
    endtask

    task automatic test_model_pattern();
        string exp;
        pk_data[0] = 8'h7E; pk_data[1] = 8'hFF; pk_data[2] = 8'h3F; pk_n = 3; pk_supply = 3;
        exp = model_bits(3);
        run_packet();
        total++; if (obs != exp) begin bad++; $display("FAIL model_bits got=%s want=%s", obs, exp); end
        total++; if (eop_at !== exp.len() + 1) begin bad++; $display("FAIL model_eop got=%0d want=%0d", eop_at, exp.len() + 1); end
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b0;
        bus.tx_valid = 1'b0; bus.tx_data = 8'h00; bus.tx_last = 1'b0;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_stuff_at_end();
        test_stuff_across();
        test_underrun();
        test_reset_mid();
        test_model_pattern();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
